// File: rtl/iiitb_sfifo_wr_arbiter.sv
// Round-robin arbiter that shares one sync-FIFO write port among N_REQ producers.
// Grants are combinational (zero latency); an owner may hold the port for up to MAX_BURST beats.
module iiitb_sfifo_wr_arbiter #(
  parameter int N_REQ     = 2,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   data,
  output logic [N_REQ-1:0]          gnt,
  input  logic                      fifo_full,
  output logic                      fifo_write,
  output logic [DATA_W-1:0]         fifo_data,
  output logic [OW-1:0]             owner_id,
  output logic                      busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state, state_nxt;
  logic [OW-1:0] ptr, ptr_nxt;
  logic [OW-1:0] owner, owner_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [OW:0]   pick_res;
  logic          found;
  logic [OW-1:0] sel;

  function automatic logic [OW-1:0] inc_mod(input logic [OW-1:0] p);
    if (int'(p) + 1 >= N_REQ) return '0;
    return p + 1'b1;
  endfunction

  // Walk from the highest offset down so the last hit is the one closest to ptr.
  function automatic logic [OW:0] pick(input logic [OW-1:0] p, input logic [N_REQ-1:0] r);
    logic [OW:0] res;
    int          idx;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (r[idx]) res = {1'b1, OW'(idx)};
    end
    return res;
  endfunction

  assign pick_res = pick(ptr, req);
  assign found    = pick_res[OW];
  assign sel      = pick_res[OW-1:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    gnt       = '0;
    case (state)
      IDLE: begin
        if (!fifo_full && found) begin
          gnt[sel]  = 1'b1;
          owner_nxt = sel;
          if (MAX_BURST > 1) begin
            state_nxt = BURST;
            cnt_nxt   = CW'(1);
          end else begin
            ptr_nxt = inc_mod(sel);
          end
        end
      end
      BURST: begin
        if (!req[owner]) begin
          state_nxt = IDLE;
          ptr_nxt   = inc_mod(owner);
          cnt_nxt   = '0;
        end else if (!fifo_full) begin
          gnt[owner] = 1'b1;
          if (cnt == CW'(MAX_BURST - 1)) begin
            state_nxt = IDLE;
            ptr_nxt   = inc_mod(owner);
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (RST) gnt = '0;
  end

  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i] && gnt[i]) fifo_data = data[i*DATA_W +: DATA_W];
    end
  end

  assign fifo_write = |(req & gnt);
  assign owner_id   = owner;
  assign busy       = (state == BURST);

endmodule
